// File: rtl/btn_debounce_pkg.sv
// Shared state encoding and 16 MHz timing defaults for the user-button debouncer.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        BTN_RELEASED      = 2'b00,
        BTN_PRESS_CHECK   = 2'b01,
        BTN_PRESSED       = 2'b10,
        BTN_RELEASE_CHECK = 2'b11
    } btn_state_e;

    localparam int unsigned BTN_DEBOUNCE_CYCLES_16MHZ   = 16000;
    localparam int unsigned BTN_LONG_PRESS_CYCLES_16MHZ = 8000000;

    // Counter width for a terminal count of cycles-1; never narrower than 1 bit.
    function automatic int unsigned btn_cnt_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/btn_debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pin, synchronous reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/btn_debounce.sv
// User-button debouncer: sync, per-edge stability check, press/release/long pulses, press count.
// Long-press detection is built only when BTN_LONG_PRESS_EN is defined.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = BTN_DEBOUNCE_CYCLES_16MHZ,
    parameter int unsigned LONG_PRESS_CYCLES = BTN_LONG_PRESS_CYCLES_16MHZ,
    parameter int unsigned BTN_ACTIVE_LOW    = 0
) (
    input  logic       clk_16mhz,
    input  logic       rst,
    input  logic       btn_usr,
    output logic       btn_level,
    output logic       btn_press,
    output logic       btn_release,
    output logic       btn_long,
    output logic [7:0] press_count
);

    localparam int unsigned       DB_W    = btn_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic       pin_in;
    logic       s;

    btn_state_e      state_q, state_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic [7:0]      count_q, count_d;

    assign pin_in = (BTN_ACTIVE_LOW != 0) ? ~btn_usr : btn_usr;

    sync_2ff u_sync (
        .clk (clk_16mhz),
        .rst (rst),
        .d   (pin_in),
        .q   (s)
    );

    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        count_d   = count_q;
        unique case (state_q)
            BTN_RELEASED: begin
                if (s) begin
                    state_d  = BTN_PRESS_CHECK;
                    db_cnt_d = '0;
                end
            end
            BTN_PRESS_CHECK: begin
                if (!s) begin
                    state_d  = BTN_RELEASED;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = BTN_PRESSED;
                    db_cnt_d = '0;
                    press_d  = 1'b1;
                    count_d  = count_q + 8'd1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            BTN_PRESSED: begin
                if (!s) begin
                    state_d  = BTN_RELEASE_CHECK;
                    db_cnt_d = '0;
                end
            end
            BTN_RELEASE_CHECK: begin
                if (s) begin
                    state_d  = BTN_PRESSED;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = BTN_RELEASED;
                    db_cnt_d  = '0;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: begin
                state_d  = BTN_RELEASED;
                db_cnt_d = '0;
            end
        endcase
        // Level is registered from the next state so it moves on the same edge as the pulses.
        level_d = (state_d == BTN_PRESSED) || (state_d == BTN_RELEASE_CHECK);
    end

    always_ff @(posedge clk_16mhz) begin
        if (rst) begin
            state_q   <= BTN_RELEASED;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            count_q   <= count_d;
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int unsigned     LP_W    = btn_cnt_width(LONG_PRESS_CYCLES);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);

    logic [LP_W-1:0] long_cnt_q, long_cnt_d;
    logic            long_done_q, long_done_d;
    logic            long_q, long_d;

    // The counter only advances in steady PRESSED; a release bounce pauses it but never re-arms.
    always_comb begin
        long_cnt_d  = long_cnt_q;
        long_done_d = long_done_q;
        long_d      = 1'b0;
        if (press_d) begin
            long_cnt_d  = '0;
            long_done_d = 1'b0;
        end else if ((state_q == BTN_PRESSED) && s && !long_done_q) begin
            if (long_cnt_q == LP_LAST) begin
                long_d      = 1'b1;
                long_done_d = 1'b1;
            end else begin
                long_cnt_d = long_cnt_q + LP_W'(1);
            end
        end
    end

    always_ff @(posedge clk_16mhz) begin
        if (rst) begin
            long_cnt_q  <= '0;
            long_done_q <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            long_cnt_q  <= long_cnt_d;
            long_done_q <= long_done_d;
            long_q      <= long_d;
        end
    end

    assign btn_long = long_q;
`else
    assign btn_long = 1'b0;
`endif

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign press_count = count_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: run-length reference model checked every cycle, plus directed latency checks.
module tb_btn_debounce;

    localparam int D = 8;
    localparam int L = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pin = 1'b0;
    logic       btn_level;
    logic       btn_press;
    logic       btn_release;
    logic       btn_long;
    logic [7:0] press_count;

    int checks   = 0;
    int failures = 0;
    longint cyc  = 0;

    btn_debounce #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L),
        .BTN_ACTIVE_LOW    (0)
    ) dut (
        .clk_16mhz   (clk),
        .rst         (rst),
        .btn_usr     (pin),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Reference model: the synchronised pin is the pin two samples late; the level flips once
    // D+1 consecutive samples disagree with it; the hold time counts steady pressed samples.
    bit   chk_en    = 0;
    bit   m_sync1   = 0;
    bit   m_sync2   = 0;
    bit   m_level   = 0;
    bit   m_press   = 0;
    bit   m_release = 0;
    bit   m_long    = 0;
    bit   m_fired   = 0;
    int   m_run     = 0;
    int   m_hold    = 0;
    int   m_count   = 0;

    always @(posedge clk) begin
        bit s;
        bit steady;
        if (rst) begin
            m_sync1 = 0; m_sync2 = 0; m_level = 0; m_run = 0; m_count = 0;
            m_press = 0; m_release = 0; m_long = 0; m_hold = 0; m_fired = 0;
            chk_en  = 1;
        end else begin
            s         = m_sync2;
            m_sync2   = m_sync1;
            m_sync1   = pin;
            m_press   = 0;
            m_release = 0;
            m_long    = 0;
            steady    = (m_run == 0);
            if (s != m_level) m_run++;
            else              m_run = 0;
            if (m_run == D + 1) begin
                m_level = s;
                m_run   = 0;
                if (m_level) begin
                    m_press = 1;
                    m_count = (m_count + 1) % 256;
                    m_hold  = 0;
                    m_fired = 0;
                end else begin
                    m_release = 1;
                end
            end else if (m_level && s && steady) begin
`ifdef BTN_LONG_PRESS_EN
                m_hold++;
                if (m_hold == L && !m_fired) begin
                    m_long  = 1;
                    m_fired = 1;
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("level",   btn_level,   m_level);
            chk("press",   btn_press,   m_press);
            chk("release", btn_release, m_release);
            chk("long",    btn_long,    m_long);
            chk("count",   press_count, m_count);
        end
    end

    // Event log used by the directed latency checks.
    int     n_press = 0, n_release = 0, n_long = 0;
    longint press_cyc = 0, release_cyc = 0, long_cyc = 0;

    always @(negedge clk) begin
        if (btn_press === 1'b1)   begin n_press++;   press_cyc   = cyc; end
        if (btn_release === 1'b1) begin n_release++; release_cyc = cyc; end
        if (btn_long === 1'b1)    begin n_long++;    long_cyc    = cyc; end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        longint t0;
        int p0, r0, l0;

        tick(3);
        chk("rst_level", btn_level, 0);
        chk("rst_press", btn_press, 0);
        chk("rst_count", press_count, 0);
        rst = 1'b0;

        // Clean press and release.
        t0 = cyc; p0 = n_press; l0 = n_long;
        pin = 1'b1;
        tick(100);
        chk("t1_press_n",   n_press - p0, 1);
        chk("t1_press_lat", 32'(press_cyc - t0), 11);
        chk("t1_level",     btn_level, 1);
        chk("t1_count",     press_count, 1);
`ifdef BTN_LONG_PRESS_EN
        chk("t1_long_n",    n_long - l0, 1);
        chk("t1_long_lat",  32'(long_cyc - press_cyc), 32);
`else
        chk("t1_long_n",    n_long - l0, 0);
`endif
        t0 = cyc; r0 = n_release;
        pin = 1'b0;
        tick(30);
        chk("t1_rel_n",   n_release - r0, 1);
        chk("t1_rel_lat", 32'(release_cyc - t0), 11);
        chk("t1_level0",  btn_level, 0);

        // Bouncing press.
        p0 = n_press;
        pin = 1'b1; tick(3);
        pin = 1'b0; tick(3);
        pin = 1'b1; tick(3);
        pin = 1'b0; tick(3);
        t0 = cyc;
        pin = 1'b1;
        tick(40);
        chk("t2_press_n",   n_press - p0, 1);
        chk("t2_press_lat", 32'(press_cyc - t0), 11);
        chk("t2_count",     press_count, 2);
        pin = 1'b0;
        tick(30);

        // Release glitch inside PRESSED.
        p0 = n_press; l0 = n_long;
        pin = 1'b1;
        tick(50);
        r0 = n_release;
        pin = 1'b0; tick(5);
        pin = 1'b1; tick(60);
        chk("t3_rel_n", n_release - r0, 0);
        chk("t3_level", btn_level, 1);
        chk("t3_count", press_count, 3);
`ifdef BTN_LONG_PRESS_EN
        chk("t3_long_n", n_long - l0, 1);
`else
        chk("t3_long_n", n_long - l0, 0);
`endif
        pin = 1'b0;
        tick(30);
        chk("t3_rel_after", n_release - r0, 1);

        // 256 presses wrap the counter back to 0.
        rst = 1'b1; tick(2); rst = 1'b0;
        p0 = n_press;
        for (int i = 0; i < 256; i++) begin
            pin = 1'b1; tick(14);
            pin = 1'b0; tick(16);
        end
        chk("t4_press_n", n_press - p0, 256);
        chk("t4_count",   press_count, 0);

        // Reset during PRESS_CHECK with the pin held.
        p0 = n_press;
        pin = 1'b1;
        tick(6);
        rst = 1'b1;
        tick(2);
        chk("t5_rst_level", btn_level, 0);
        chk("t5_rst_press", btn_press, 0);
        chk("t5_rst_count", press_count, 0);
        chk("t5_no_early",  n_press - p0, 0);
        rst = 1'b0;
        t0 = cyc;
        tick(30);
        chk("t5_press_n",   n_press - p0, 1);
        chk("t5_press_lat", 32'(press_cyc - t0), 11);
        chk("t5_count",     press_count, 1);
        pin = 1'b0;
        tick(30);

        // Random bouncy traffic with occasional resets, checked by the model.
        for (int i = 0; i < 300; i++) begin
            pin = ~pin;
            if ($urandom_range(0, 3) == 0) tick($urandom_range(20, 60));
            else                           tick($urandom_range(1, 12));
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                tick($urandom_range(1, 3));
                rst = 1'b0;
            end
        end
        pin = 1'b0;
        tick(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
